// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: FSM state encoding and address-field split.
package cpu_types_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  // Fields are kept at full width so one type serves every NSETS/BLKWORDS choice.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] offset;
  } icache_addr_t;

  function automatic icache_addr_t splitAddr(input logic [31:0] addr,
                                             input int ixBits,
                                             input int woBits);
    icache_addr_t f;
    f.offset = (addr >> 2) & ((32'd1 << woBits) - 32'd1);
    f.index  = (addr >> (2 + woBits)) & ((32'd1 << ixBits) - 32'd1);
    f.tag    = addr >> (2 + woBits + ixBits);
    return f;
  endfunction

endpackage

// File: rtl/icache_set.sv
// One direct-mapped set: valid bit (reset), tag and block data (not reset).
module icache_set #(
  parameter int BLKWORDS = 2,
  parameter int TAGW     = 25,
  parameter int CW       = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     clrValid,
  input  logic                     wordWen,
  input  logic [CW-1:0]            wordSel,
  input  logic [31:0]              wordData,
  input  logic                     tagWen,
  input  logic [TAGW-1:0]          tagData,
  output logic                     valid,
  output logic [TAGW-1:0]          tag,
  output logic [BLKWORDS-1:0][31:0] block
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
    end else if (clrValid) begin
      valid <= 1'b0;
    end else if (tagWen) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (tagWen) begin
      tag <= tagData;
    end
    if (wordWen) begin
      block[wordSel] <= wordData;
    end
  end

endmodule

// File: rtl/param_icache.sv
// Parameterised direct-mapped instruction cache with a two-state refill FSM.
// Optional hit/miss statistics outputs are built when ICACHE_STATS_EN is defined.
module param_icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS    = 16,
  parameter int BLKWORDS = 2,
  parameter int CPUID    = 0
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          imemREN,
  input  logic [31:0]   imemaddr,
  input  logic          flush,
  output logic          ihit,
  output logic [31:0]   imemload,
  input  logic          iwait,
  input  logic [31:0]   iload,
  output logic          iREN,
  output logic [31:0]   iaddr,
  output icache_state_t stateDbg
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int WO   = $clog2(BLKWORDS);
  localparam int IX   = $clog2(NSETS);
  localparam int TAGW = 30 - WO - IX;
  localparam int CW   = (WO > 0) ? WO : 1;

  if (CPUID < 0) begin : gCpuidRange
  end

  icache_state_t   state;
  logic [TAGW-1:0] missTag;
  logic [IX-1:0]   missIdx;
  logic [CW-1:0]   cnt;

  icache_addr_t    req;
  logic [TAGW-1:0] reqTag;
  logic [IX-1:0]   reqIdx;
  logic [CW-1:0]   reqOff;

  logic                      setValid [NSETS];
  logic [TAGW-1:0]           setTag   [NSETS];
  logic [BLKWORDS-1:0][31:0] setData  [NSETS];

  logic hit, missStart, accept, lastWord;

  assign req    = splitAddr(imemaddr, IX, WO);
  assign reqTag = req.tag[TAGW-1:0];
  assign reqIdx = req.index[IX-1:0];
  assign reqOff = req.offset[CW-1:0];

  assign hit       = (state == IDLE) && imemREN && !flush &&
                     setValid[reqIdx] && (setTag[reqIdx] == reqTag);
  assign missStart = (state == IDLE) && imemREN && !flush && !hit;
  // Memory handshake: a word transfers on every cycle with iREN=1 and iwait=0;
  // iaddr is held stable until that happens.
  assign accept    = (state == REFILL) && !iwait && !flush;
  assign lastWord  = (cnt == CW'(BLKWORDS - 1));

  for (genvar s = 0; s < NSETS; s++) begin : gSet
    icache_set #(
      .BLKWORDS (BLKWORDS),
      .TAGW     (TAGW),
      .CW       (CW)
    ) uSet (
      .CLK      (CLK),
      .nRST     (nRST),
      .clrValid (flush),
      .wordWen  (accept && (missIdx == IX'(s))),
      .wordSel  (cnt),
      .wordData (iload),
      .tagWen   (accept && lastWord && (missIdx == IX'(s))),
      .tagData  (missTag),
      .valid    (setValid[s]),
      .tag      (setTag[s]),
      .block    (setData[s])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      missTag <= '0;
      missIdx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (missStart) begin
            state   <= REFILL;
            missTag <= reqTag;
            missIdx <= reqIdx;
            cnt     <= '0;
          end
        end
        REFILL: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!iwait) begin
            if (lastWord) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ihit     = hit;
  assign imemload = setData[reqIdx][reqOff];
  assign iREN     = (state == REFILL);
  assign stateDbg = state;

  always_comb begin
    iaddr = {imemaddr[31:2], 2'b00};
    if (state == REFILL) begin
      iaddr = (32'(missTag) << (IX + WO + 2)) |
              (32'(missIdx) << (WO + 2)) |
              (32'(cnt) << 2);
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (missStart) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_icache.sv
// Bench for param_icache: directed fetch scenarios plus randomized traffic checked
// every cycle against a block-level cache model with an expected-address queue.
module tb_param_icache;
  import cpu_types_pkg::*;

  localparam int NSETS    = 16;
  localparam int BLKWORDS = 2;
  localparam int WO       = $clog2(BLKWORDS);

  logic          CLK      = 1'b0;
  logic          nRST     = 1'b0;
  logic          imemREN  = 1'b0;
  logic [31:0]   imemaddr = 32'h0;
  logic          flush    = 1'b0;
  logic          iwait    = 1'b0;
  logic          ihit;
  logic [31:0]   imemload;
  logic [31:0]   iload;
  logic          iREN;
  logic [31:0]   iaddr;
  icache_state_t stateDbg;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  int nTests = 0;
  int nFail  = 0;
  bit armed  = 1'b0;

  // clock / reset
  always #5 CLK = ~CLK;

  param_icache #(
    .NSETS    (NSETS),
    .BLKWORDS (BLKWORDS),
    .CPUID    (3)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iwait    (iwait),
    .iload    (iload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .stateDbg (stateDbg)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // backing memory contents
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA0001;
    if (a == 32'h44) return 32'hAAAA0002;
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign iload = memData(iaddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: per-set block number + data, queue of refill word addresses
  bit          mValid [NSETS];
  logic [31:0] mBlk   [NSETS];
  logic [31:0] mData  [NSETS][BLKWORDS];
  logic [31:0] exp_q[$];
  logic [31:0] rBlk;
  bit   [31:0] mHits   = 0;
  bit   [31:0] mMisses = 0;

  function automatic bit modelHit();
    logic [31:0] blk;
    int idx;
    blk = imemaddr >> (2 + WO);
    idx = int'(blk % NSETS);
    return (exp_q.size() == 0) && imemREN && !flush && mValid[idx] && (mBlk[idx] == blk);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    logic [31:0] a;
    int idx;
    if (!nRST) begin
      foreach (mValid[i]) mValid[i] = 1'b0;
      exp_q.delete();
      mHits   = 0;
      mMisses = 0;
    end else if (flush) begin
      foreach (mValid[i]) mValid[i] = 1'b0;
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (modelHit()) begin
        mHits++;
      end else if (imemREN) begin
        rBlk = imemaddr >> (2 + WO);
        for (int w = 0; w < BLKWORDS; w++) exp_q.push_back((rBlk << (2 + WO)) + 32'(4 * w));
        mMisses++;
      end
    end else if (!iwait) begin
      a   = exp_q.pop_front();
      idx = int'(rBlk % NSETS);
      mData[idx][int'((a >> 2) % BLKWORDS)] = memData(a);
      if (exp_q.size() == 0) begin
        mValid[idx] = 1'b1;
        mBlk[idx]   = rBlk;
      end
    end
  end

  // compare process
  always @(negedge CLK) begin
    logic [31:0] blk, expIaddr;
    int idx, off;
    bit expHit, expIren;
    if (armed) begin
      blk = imemaddr >> (2 + WO);
      idx = int'(blk % NSETS);
      off = int'((imemaddr >> 2) % BLKWORDS);
      if (exp_q.size() == 0) begin
        expIren  = 1'b0;
        expIaddr = {imemaddr[31:2], 2'b00};
        expHit   = modelHit();
      end else begin
        expIren  = 1'b1;
        expIaddr = exp_q[0];
        expHit   = 1'b0;
      end
      check("ihit", ihit, expHit);
      check("iREN", iREN, expIren);
      check("iaddr", iaddr, expIaddr);
      check("state", stateDbg, expIren ? REFILL : IDLE);
      if (expHit) check("imemload", imemload, mData[idx][off]);
`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count, mHits);
      check("miss_count", miss_count, mMisses);
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic refillWait(input logic [31:0] base);
    for (int w = 0; w < BLKWORDS; w++) begin
      tick();
      mid();
      check("refill_iaddr", iaddr, base + 32'(4 * w));
      check("refill_iren", iREN, 1);
    end
  endtask

  initial begin
    logic [31:0] tg, ix, of;
    int r;
    repeat (2) @(posedge CLK);
    #1;
    armed = 1'b1;
    mid();
    check("rst_ihit", ihit, 0);
    check("rst_iren", iREN, 0);

    // first miss on 0x40, then hits on both words
    tick();
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
    mid();
    check("miss40_ihit", ihit, 0);
    check("miss40_iren", iREN, 0);
    refillWait(32'h40);
    tick(); mid();
    check("hit40_ihit", ihit, 1);
    check("hit40_load", imemload, 32'hAAAA0001);
    tick(); imemaddr = 32'h44; mid();
    check("hit44_ihit", ihit, 1);
    check("hit44_load", imemload, 32'hAAAA0002);
    check("hit44_iren", iREN, 0);
    tick(); imemaddr = 32'h40; mid();
    check("hit40b_ihit", ihit, 1);
    tick(); imemREN = 1'b0; mid();
    check("idle_ihit", ihit, 0);
`ifdef ICACHE_STATS_EN
    check("stats_hits", hit_count, 32'd3);
    check("stats_misses", miss_count, 32'd1);
`endif

    // conflicting tag in the same set evicts the block
    tick(); imemREN = 1'b1; imemaddr = 32'h840; mid();
    check("miss840_ihit", ihit, 0);
    refillWait(32'h840);
    tick(); mid();
    check("hit840_load", imemload, 32'hE4E80840);
    tick(); imemaddr = 32'h40; mid();
    check("remiss40_ihit", ihit, 0);
    refillWait(32'h40);
    tick(); mid();
    check("rehit40_load", imemload, 32'hAAAA0001);

    // three wait cycles before each accepted word
    tick(); imemaddr = 32'h100; iwait = 1'b1; mid();
    check("miss100_ihit", ihit, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      iwait = (k % 4 == 3) ? 1'b0 : 1'b1;
      imemaddr = 32'h0000_0ABC;
      mid();
      check("wait_iren", iREN, 1);
      check("wait_iaddr", iaddr, 32'h100 + 32'(4 * (k / 4)));
    end
    tick(); imemaddr = 32'h100; iwait = 1'b0; mid();
    check("wait_done_iren", iREN, 0);
    check("hit100_load", imemload, 32'hEDA80100);

    // flush in the second refill cycle aborts the refill
    tick(); imemaddr = 32'h200; mid();
    check("miss200_ihit", ihit, 0);
    tick(); mid();
    check("fl_refill0", iaddr, 32'h200);
    tick(); flush = 1'b1; mid();
    check("fl_iren", iREN, 1);
    check("fl_ihit", ihit, 0);
    tick(); flush = 1'b0; imemaddr = 32'h40; mid();
    check("fl_idle_iren", iREN, 0);
    check("fl_miss40", ihit, 0);
    refillWait(32'h40);
    tick(); imemaddr = 32'h200; mid();
    check("fl_miss200", ihit, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      r = $urandom_range(0, 199);
      nRST = (r < 2) ? 1'b0 : 1'b1;
      flush = (r >= 2 && r < 8) ? 1'b1 : 1'b0;
      imemREN = ($urandom_range(0, 3) != 0);
      iwait = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        imemaddr = $urandom();
      end else begin
        tg = $urandom_range(0, 3);
        ix = $urandom_range(0, NSETS - 1);
        of = $urandom_range(0, BLKWORDS - 1);
        imemaddr = ((tg * NSETS + ix) * BLKWORDS + of) * 4 + $urandom_range(0, 3);
      end
    end
    tick();
    nRST = 1'b1; flush = 1'b0; imemREN = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
